// File: rtl/unidade_controle_aprendizado_pkg.sv
// rtl/unidade_controle_aprendizado_pkg.sv - state codes and error bounds shared by the learning-mode FSM and datapath debug decode
package unidade_controle_aprendizado_pkg;

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      MOSTRA      = 4'h2,
      PROX_MOSTRA = 4'h3,
      FIM_MOSTRA  = 4'h4,
      ESPERA      = 4'h5,
      REGISTRA    = 4'h6,
      FEEDBACK    = 4'h7,
      COMPARA     = 4'h8,
      PROX_JOGADA = 4'h9,
      NOVA_RODADA = 4'hA,
      ERRO        = 4'hB,
      FIM_ACERTO  = 4'hC,
      FIM_ERRO    = 4'hD,
      FIM_TIMEOUT = 4'hE
   } estado_t;

   localparam int MAX_ERROS_MIN = 1;
   localparam int MAX_ERROS_MAX = 7;
   localparam logic [2:0] ERROS_SATURADO = 3'd7;

   function automatic logic [2:0] incrementa_saturado(input logic [2:0] valor);
      return (valor == ERROS_SATURADO) ? valor : valor + 3'd1;
   endfunction

endpackage

// File: rtl/unidade_controle_aprendizado_contador_erros.sv
// rtl/unidade_controle_aprendizado_contador_erros.sv - saturating 3-bit wrong-note counter
import unidade_controle_aprendizado_pkg::*;

module contador_erros (
   input  logic       clock,
   input  logic       reset,
   input  logic       limpa,
   input  logic       incrementa,
   output logic [2:0] erros
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         erros <= 3'd0;
      end else if (limpa) begin
         erros <= 3'd0;
      end else if (incrementa) begin
         erros <= incrementa_saturado(erros);
      end
   end

endmodule

// File: rtl/unidade_controle_aprendizado.sv
// rtl/unidade_controle_aprendizado.sv - learning-mode game control FSM
import unidade_controle_aprendizado_pkg::*;

module unidade_controle_aprendizado #(
   parameter int MAX_ERROS = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       nota_feita,
   input  logic       nota_correta,
   input  logic       enderecoIgualRodada,
   input  logic       fimCR,
   input  logic       fim_musica,
   input  logic       fimTF,
   input  logic       fimTempo,
   output logic       zeraR,
   output logic       registraR,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraCR,
   output logic       contaCR,
   output logic       zeraTF,
   output logic       contaTF,
   output logic       zeraTempo,
   output logic       contaTempo,
   output logic       zeraMetro,
   output logic       leds_mem,
   output logic       ativa_leds,
   output logic       toca,
   output logic       registra_erro,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [2:0] erros,
   output logic [3:0] db_estado
);

   // Out-of-range parameter values are clamped into the legal window.
   localparam int MAX_ERROS_EFETIVO =
      (MAX_ERROS < MAX_ERROS_MIN) ? MAX_ERROS_MIN :
      (MAX_ERROS > MAX_ERROS_MAX) ? MAX_ERROS_MAX : MAX_ERROS;
   localparam logic [2:0] LIMITE_ERROS = MAX_ERROS_EFETIVO[2:0];

   estado_t    estado;
   estado_t    estado_prox;
   logic [2:0] erros_inc;
   logic       fim_por_erro;

   contador_erros u_contador_erros (
      .clock      (clock),
      .reset      (reset),
      .limpa      (estado == PREPARA),
      .incrementa (estado == ERRO),
      .erros      (erros)
   );

   // In ERRO the counter still holds the old value; decide on the value it is about to take.
   assign erros_inc    = incrementa_saturado(erros);
   assign fim_por_erro = (erros_inc >= LIMITE_ERROS);
   assign db_estado    = estado;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= INICIAL;
      end else begin
         estado <= estado_prox;
      end
   end

   always_comb begin
      estado_prox = estado;
      case (estado)
         INICIAL:     if (iniciar) estado_prox = PREPARA;
         PREPARA:     estado_prox = MOSTRA;
         MOSTRA: begin
            if (fimTF) estado_prox = enderecoIgualRodada ? FIM_MOSTRA : PROX_MOSTRA;
         end
         PROX_MOSTRA: estado_prox = MOSTRA;
         FIM_MOSTRA:  estado_prox = ESPERA;
         ESPERA: begin
            if (nota_feita)     estado_prox = REGISTRA;
            else if (fimTempo)  estado_prox = FIM_TIMEOUT;
         end
         REGISTRA:    estado_prox = FEEDBACK;
         FEEDBACK:    if (fimTF && !nota_feita) estado_prox = COMPARA;
         COMPARA: begin
            if (!nota_correta)             estado_prox = ERRO;
            else if (!enderecoIgualRodada) estado_prox = PROX_JOGADA;
            else if (fimCR || fim_musica)  estado_prox = FIM_ACERTO;
            else                           estado_prox = NOVA_RODADA;
         end
         PROX_JOGADA: estado_prox = ESPERA;
         NOVA_RODADA: estado_prox = MOSTRA;
         ERRO:        estado_prox = fim_por_erro ? FIM_ERRO : MOSTRA;
         FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
            if (iniciar) estado_prox = PREPARA;
         end
         default:     estado_prox = INICIAL;
      endcase
   end

   always_comb begin
      zeraR         = 1'b0;
      registraR     = 1'b0;
      zeraC         = 1'b0;
      contaC        = 1'b0;
      zeraCR        = 1'b0;
      contaCR       = 1'b0;
      zeraTF        = 1'b0;
      contaTF       = 1'b0;
      zeraTempo     = 1'b0;
      contaTempo    = 1'b0;
      zeraMetro     = 1'b0;
      leds_mem      = 1'b0;
      ativa_leds    = 1'b0;
      toca          = 1'b0;
      registra_erro = 1'b0;
      pronto        = 1'b0;
      acertou       = 1'b0;
      errou         = 1'b0;
      timeout       = 1'b0;
      case (estado)
         PREPARA: begin
            zeraC     = 1'b1;
            zeraCR    = 1'b1;
            zeraR     = 1'b1;
            zeraTF    = 1'b1;
            zeraTempo = 1'b1;
            zeraMetro = 1'b1;
         end
         MOSTRA: begin
            leds_mem   = 1'b1;
            ativa_leds = 1'b1;
            toca       = 1'b1;
            contaTF    = 1'b1;
         end
         PROX_MOSTRA: begin
            contaC = 1'b1;
            zeraTF = 1'b1;
         end
         FIM_MOSTRA: begin
            zeraC     = 1'b1;
            zeraTF    = 1'b1;
            zeraTempo = 1'b1;
            zeraR     = 1'b1;
         end
         ESPERA:      contaTempo = 1'b1;
         REGISTRA: begin
            registraR     = 1'b1;
            registra_erro = 1'b1;
         end
         FEEDBACK: begin
            ativa_leds = 1'b1;
            toca       = 1'b1;
            contaTF    = 1'b1;
         end
         COMPARA:     zeraTF = 1'b1;
         PROX_JOGADA: begin
            contaC    = 1'b1;
            zeraTempo = 1'b1;
            zeraR     = 1'b1;
         end
         NOVA_RODADA: begin
            contaCR = 1'b1;
            zeraC   = 1'b1;
            zeraTF  = 1'b1;
            zeraR   = 1'b1;
         end
         ERRO: begin
            // Only rewind the round display when play continues.
            zeraC  = !fim_por_erro;
            zeraTF = !fim_por_erro;
            zeraR  = !fim_por_erro;
         end
         FIM_ACERTO: begin
            pronto  = 1'b1;
            acertou = 1'b1;
         end
         FIM_ERRO: begin
            pronto = 1'b1;
            errou  = 1'b1;
         end
         FIM_TIMEOUT: begin
            pronto  = 1'b1;
            timeout = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_unidade_controle_aprendizado.sv
// tb/tb_unidade_controle_aprendizado.sv - directed self-checking bench for the learning-mode FSM
module tb_unidade_controle_aprendizado;

   logic clock = 1'b0;
   logic reset, iniciar, nota_feita, nota_correta, enderecoIgualRodada;
   logic fimCR, fim_musica, fimTF, fimTempo;
   logic zeraR, registraR, zeraC, contaC, zeraCR, contaCR, zeraTF, contaTF;
   logic zeraTempo, contaTempo, zeraMetro, leds_mem, ativa_leds, toca, registra_erro;
   logic pronto, acertou, errou, timeout;
   logic [2:0] erros;
   logic [3:0] db_estado;
   logic [14:0] ctrl;
   logic [3:0]  status;

   int checks = 0;
   int errors = 0;

   // Expected control vectors {zeraR,registraR,zeraC,contaC,zeraCR,contaCR,zeraTF,contaTF,
   // zeraTempo,contaTempo,zeraMetro,leds_mem,ativa_leds,toca,registra_erro}
   localparam logic [14:0] C_NONE   = 15'b000000000000000;
   localparam logic [14:0] C_PREP   = 15'b101010101010000;
   localparam logic [14:0] C_MOSTRA = 15'b000000010001110;
   localparam logic [14:0] C_PMOST  = 15'b000100100000000;
   localparam logic [14:0] C_FMOST  = 15'b101000101000000;
   localparam logic [14:0] C_ESPERA = 15'b000000000100000;
   localparam logic [14:0] C_REG    = 15'b010000000000001;
   localparam logic [14:0] C_FEED   = 15'b000000010000110;
   localparam logic [14:0] C_COMP   = 15'b000000100000000;
   localparam logic [14:0] C_PJOG   = 15'b100100001000000;
   localparam logic [14:0] C_NOVA   = 15'b101001100000000;
   localparam logic [14:0] C_ERRO   = 15'b101000100000000;

   assign ctrl = {zeraR, registraR, zeraC, contaC, zeraCR, contaCR, zeraTF, contaTF,
                  zeraTempo, contaTempo, zeraMetro, leds_mem, ativa_leds, toca, registra_erro};
   assign status = {pronto, acertou, errou, timeout};

   always #5 clock = ~clock;

   unidade_controle_aprendizado #(.MAX_ERROS(3)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .nota_feita(nota_feita),
      .nota_correta(nota_correta), .enderecoIgualRodada(enderecoIgualRodada),
      .fimCR(fimCR), .fim_musica(fim_musica), .fimTF(fimTF), .fimTempo(fimTempo),
      .zeraR(zeraR), .registraR(registraR), .zeraC(zeraC), .contaC(contaC),
      .zeraCR(zeraCR), .contaCR(contaCR), .zeraTF(zeraTF), .contaTF(contaTF),
      .zeraTempo(zeraTempo), .contaTempo(contaTempo), .zeraMetro(zeraMetro),
      .leds_mem(leds_mem), .ativa_leds(ativa_leds), .toca(toca),
      .registra_erro(registra_erro), .pronto(pronto), .acertou(acertou),
      .errou(errou), .timeout(timeout), .erros(erros), .db_estado(db_estado)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic limpa_entradas;
      iniciar = 0; nota_feita = 0; nota_correta = 0; enderecoIgualRodada = 0;
      fimCR = 0; fim_musica = 0; fimTF = 0; fimTempo = 0;
   endtask

   // Stimulus-only walk: start pulse from an idle/final state through to ESPERA.
   task automatic inicia_ate_espera;
      iniciar = 1; tick(); iniciar = 0;
      tick();
      fimTF = 1; enderecoIgualRodada = 1; tick();
      fimTF = 0; tick();
   endtask

   task automatic test_reset;
      limpa_entradas();
      reset = 0;
      #12;
      if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_state: got %h expected 0", db_estado); end checks++;
      if (ctrl !== C_NONE) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_NONE); end checks++;
      if (status !== 4'b0 || erros !== 3'd0) begin errors++; $display("FAIL reset_status: got %b/%0d expected 0000/0", status, erros); end checks++;
      tick(); reset = 1; tick(); tick();
      if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_idle: got %h expected 0", db_estado); end checks++;
   endtask

   task automatic test_round;
      int pulsos_cr = 0;
      iniciar = 1; tick(); iniciar = 0;
      if (db_estado !== 4'h1 || ctrl !== C_PREP) begin errors++; $display("FAIL round_prepara: got %h/%b expected 1/%b", db_estado, ctrl, C_PREP); end checks++;
      tick();
      if (db_estado !== 4'h2 || ctrl !== C_MOSTRA) begin errors++; $display("FAIL round_mostra: got %h/%b expected 2/%b", db_estado, ctrl, C_MOSTRA); end checks++;
      iniciar = 1; tick(); iniciar = 0;
      if (db_estado !== 4'h2) begin errors++; $display("FAIL iniciar_ignored_mostra: got %h expected 2", db_estado); end checks++;
      fimTF = 1; enderecoIgualRodada = 1; tick();
      if (db_estado !== 4'h4 || ctrl !== C_FMOST) begin errors++; $display("FAIL round_fim_mostra: got %h/%b expected 4/%b", db_estado, ctrl, C_FMOST); end checks++;
      fimTF = 0; tick();
      if (db_estado !== 4'h5 || ctrl !== C_ESPERA) begin errors++; $display("FAIL round_espera: got %h/%b expected 5/%b", db_estado, ctrl, C_ESPERA); end checks++;
      nota_feita = 1; nota_correta = 1; tick();
      if (db_estado !== 4'h6 || ctrl !== C_REG) begin errors++; $display("FAIL round_registra: got %h/%b expected 6/%b", db_estado, ctrl, C_REG); end checks++;
      tick();
      if (db_estado !== 4'h7 || ctrl !== C_FEED) begin errors++; $display("FAIL round_feedback: got %h/%b expected 7/%b", db_estado, ctrl, C_FEED); end checks++;
      fimTF = 1; nota_feita = 0; tick();
      if (db_estado !== 4'h8 || ctrl !== C_COMP) begin errors++; $display("FAIL round_compara: got %h/%b expected 8/%b", db_estado, ctrl, C_COMP); end checks++;
      tick(); pulsos_cr += contaCR;
      if (db_estado !== 4'hA || ctrl !== C_NOVA) begin errors++; $display("FAIL round_nova_rodada: got %h/%b expected A/%b", db_estado, ctrl, C_NOVA); end checks++;
      fimTF = 0; tick(); pulsos_cr += contaCR;
      if (db_estado !== 4'h2 || pulsos_cr != 1) begin errors++; $display("FAIL round_contaCR_once: got %h/%0d expected 2/1", db_estado, pulsos_cr); end checks++;
      // Round 1: two notes, the second flagged as the end of the song.
      fimTF = 1; enderecoIgualRodada = 0; tick();
      if (db_estado !== 4'h3 || ctrl !== C_PMOST) begin errors++; $display("FAIL round_prox_mostra: got %h/%b expected 3/%b", db_estado, ctrl, C_PMOST); end checks++;
      fimTF = 0; tick();
      fimTF = 1; enderecoIgualRodada = 1; tick();
      fimTF = 0; tick();
      nota_feita = 1; enderecoIgualRodada = 0; tick(); tick();
      fimTF = 1; nota_feita = 0; tick();
      tick();
      if (db_estado !== 4'h9 || ctrl !== C_PJOG) begin errors++; $display("FAIL round_prox_jogada: got %h/%b expected 9/%b", db_estado, ctrl, C_PJOG); end checks++;
      fimTF = 0; tick();
      if (db_estado !== 4'h5) begin errors++; $display("FAIL round_back_espera: got %h expected 5", db_estado); end checks++;
      nota_feita = 1; tick(); tick();
      fimTF = 1; nota_feita = 0; enderecoIgualRodada = 1; fim_musica = 1; tick();
      tick();
      if (db_estado !== 4'hC || status !== 4'b1100 || ctrl !== C_NONE) begin errors++; $display("FAIL round_fim_acerto: got %h/%b expected C/1100", db_estado, status); end checks++;
      tick();
      if (db_estado !== 4'hC) begin errors++; $display("FAIL round_fim_hold: got %h expected C", db_estado); end checks++;
      limpa_entradas();
   endtask

   task automatic test_erros;
      iniciar = 1; tick(); iniciar = 0; tick();
      if (erros !== 3'd0 || db_estado !== 4'h2) begin errors++; $display("FAIL erros_cleared: got %0d/%h expected 0/2", erros, db_estado); end checks++;
      for (int i = 0; i < 3; i++) begin
         fimTF = 1; enderecoIgualRodada = 1; tick();
         fimTF = 0; tick();
         nota_feita = 1; nota_correta = 0; tick(); tick();
         fimTF = 1; nota_feita = 0; tick();
         fimTF = 0; tick();
         if (db_estado !== 4'hB || ctrl !== ((i < 2) ? C_ERRO : C_NONE)) begin errors++; $display("FAIL erros_estado_erro_%0d: got %h/%b", i, db_estado, ctrl); end checks++;
         tick();
         if (i < 2) begin
            if (db_estado !== 4'h2 || erros !== 3'(i + 1)) begin errors++; $display("FAIL erros_retry_%0d: got %h/%0d expected 2/%0d", i, db_estado, erros, i + 1); end checks++;
         end else begin
            if (db_estado !== 4'hD || erros !== 3'd3 || status !== 4'b1010) begin errors++; $display("FAIL erros_fim_erro: got %h/%0d/%b expected D/3/1010", db_estado, erros, status); end checks++;
         end
      end
      limpa_entradas();
   endtask

   task automatic test_timeout;
      inicia_ate_espera();
      fimTempo = 1; tick(); fimTempo = 0;
      if (db_estado !== 4'hE || status !== 4'b1001) begin errors++; $display("FAIL timeout_fim: got %h/%b expected E/1001", db_estado, status); end checks++;
      inicia_ate_espera();
      fimTempo = 1; nota_feita = 1; nota_correta = 1; tick(); fimTempo = 0;
      if (db_estado !== 4'h6) begin errors++; $display("FAIL timeout_nota_wins: got %h expected 6", db_estado); end checks++;
   endtask

   task automatic test_feedback_hold;
      tick();
      fimTF = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (db_estado !== 4'h7) begin errors++; $display("FAIL feedback_hold_%0d: got %h expected 7", i, db_estado); end checks++;
      end
      nota_feita = 0; tick();
      if (db_estado !== 4'h8) begin errors++; $display("FAIL feedback_release: got %h expected 8", db_estado); end checks++;
      limpa_entradas();
   endtask

   task automatic test_async_reset;
      reset = 0; #3; reset = 1; tick(); tick();
      inicia_ate_espera();
      nota_feita = 1; nota_correta = 0; tick(); tick();
      fimTF = 1; nota_feita = 0; tick(); tick(); tick();
      fimTF = 0;
      if (erros !== 3'd1 || db_estado !== 4'h2) begin errors++; $display("FAIL areset_setup: got %0d/%h expected 1/2", erros, db_estado); end checks++;
      fimTF = 1; enderecoIgualRodada = 1; tick(); fimTF = 0; tick();
      if (db_estado !== 4'h5) begin errors++; $display("FAIL areset_espera: got %h expected 5", db_estado); end checks++;
      #2 reset = 0; #1;
      if (db_estado !== 4'h0 || ctrl !== C_NONE || status !== 4'b0 || erros !== 3'd0) begin errors++; $display("FAIL areset_mid_cycle: got %h/%b/%b/%0d expected 0/0/0/0", db_estado, ctrl, status, erros); end checks++;
      tick(); reset = 1; tick(); tick();
      if (db_estado !== 4'h0) begin errors++; $display("FAIL areset_stays_idle: got %h expected 0", db_estado); end checks++;
      iniciar = 1; tick(); iniciar = 0;
      if (db_estado !== 4'h1) begin errors++; $display("FAIL areset_restart: got %h expected 1", db_estado); end checks++;
      limpa_entradas();
   endtask

   initial begin
      test_reset();
      test_round();
      test_erros();
      test_timeout();
      test_feedback_hold();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
